// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder BIST controller: FSM states,
// Galois LFSR tap masks (odd widths 3..31) and the golden-sum reference.
package adder_bist_pkg;

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

    // Toggle mask for a right-shifting Galois LFSR; bit t-1 set for each tap t.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            3:       lfsr_taps = 32'h0000_0006;
            5:       lfsr_taps = 32'h0000_0014;
            7:       lfsr_taps = 32'h0000_0060;
            9:       lfsr_taps = 32'h0000_0110;
            11:      lfsr_taps = 32'h0000_0500;
            13:      lfsr_taps = 32'h0000_100D;
            15:      lfsr_taps = 32'h0000_6000;
            17:      lfsr_taps = 32'h0001_2000;
            19:      lfsr_taps = 32'h0004_0023;
            21:      lfsr_taps = 32'h0014_0000;
            23:      lfsr_taps = 32'h0042_0000;
            25:      lfsr_taps = 32'h0120_0000;
            27:      lfsr_taps = 32'h0400_0013;
            29:      lfsr_taps = 32'h1400_0000;
            31:      lfsr_taps = 32'h4800_0000;
            default: lfsr_taps = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [32:0] golden_sum(input logic [31:0] a, input logic [31:0] b,
                                               input logic cin);
        golden_sum = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    endfunction

endpackage

// File: rtl/adder_bist_vecgen.sv
// Operand vector source: exhaustive index counter by default, or a Galois
// LFSR when ADDER_BIST_LFSR_EN is defined.
import adder_bist_pkg::*;

module adder_bist_vecgen #(
    parameter int N = 8
`ifdef ADDER_BIST_LFSR_EN
    , parameter int SEED = 1
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         advance,
    output logic [2*N:0] vec
);
    localparam int W = 2 * N + 1;

`ifdef ADDER_BIST_LFSR_EN
    localparam logic [W-1:0] TAPS   = W'(lfsr_taps(W));
    // The all-zero state is a lock-up state, so a zero seed becomes 1.
    localparam logic [W-1:0] SEED_V = (W'(SEED) == '0) ? W'(1) : W'(SEED);

    always_ff @(posedge clk) begin
        if (rst)
            vec <= '0;
        else if (load)
            vec <= SEED_V;
        else if (advance)
            vec <= (vec >> 1) ^ (vec[0] ? TAPS : '0);
    end
`else
    always_ff @(posedge clk) begin
        if (rst)
            vec <= '0;
        else if (load)
            vec <= '0;
        else if (advance)
            vec <= vec + W'(1);
    end
`endif

endmodule

// File: rtl/adder_bist_controller.sv
// BIST controller for an external adder: drives vectors, checks results after
// LATENCY settle cycles. Define ADDER_BIST_LFSR_EN for pseudo-random vectors.
import adder_bist_pkg::*;

module adder_bist_controller #(
    parameter int N           = 8,
    parameter int LATENCY     = 0,
    parameter int NUM_VECTORS = 256,
    parameter int SEED        = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N-1:0] dut_a,
    output logic [N-1:0] dut_b,
    output logic         dut_cin,
    input  logic [N-1:0] dut_sum,
    input  logic         dut_cout,
    output logic [15:0]  err_count,
    output logic         fail_valid,
    output logic [N-1:0] fail_a,
    output logic [N-1:0] fail_b,
    output logic         fail_cin
);
    localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (NUM_VECTORS < 1 || NUM_VECTORS > 65536 || SEED < 0 || N < 1 || N > 15) begin : g_param_check
        $error("adder_bist_controller: parameter out of range");
    end

    state_t        state;
    logic [2*N:0]  vec;
    logic          load, advance, last, mismatch;
    logic [N-1:0]  sum_q;
    logic          cout_q;
    logic [32:0]   gold;
    logic [15:0]   vcnt, err_inc;
    logic [WW-1:0] wcnt;

    adder_bist_vecgen #(
        .N(N)
`ifdef ADDER_BIST_LFSR_EN
        , .SEED(SEED)
`endif
    ) u_vecgen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .vec     (vec)
    );

    // Operands come straight off the generator register, so they only move
    // on the edge that enters DRIVE.
    assign dut_cin = vec[0];
    assign dut_b   = vec[N:1];
    assign dut_a   = vec[2*N:N+1];

    assign load     = start && (state == S_IDLE || state == S_DONE);
    assign last     = (vcnt == 16'(NUM_VECTORS - 1));
    assign advance  = (state == S_CHECK) && !last;
    assign gold     = golden_sum(32'(dut_a), 32'(dut_b), dut_cin);
    assign mismatch = gold != 33'({cout_q, sum_q});
    assign err_inc  = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

    // Adder outputs are registered first; CHECK compares what was captured
    // on the edge that entered it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= dut_sum;
            cout_q <= dut_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
            vcnt       <= '0;
            wcnt       <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_DRIVE;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_cin   <= 1'b0;
                        vcnt       <= '0;
                    end
                end
                S_DRIVE: begin
                    wcnt  <= '0;
                    state <= (LATENCY > 0) ? S_WAIT : S_CHECK;
                end
                S_WAIT: begin
                    if (wcnt == WW'(LATENCY - 1))
                        state <= S_CHECK;
                    else
                        wcnt <= wcnt + WW'(1);
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_inc;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_a     <= dut_a;
                            fail_b     <= dut_b;
                            fail_cin   <= dut_cin;
                        end
                    end
                    if (last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (err_count == 16'd0);
                    end else begin
                        vcnt  <= vcnt + 16'd1;
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
